// File: rtl/test_regblock_arb_pkg.sv
// Shared types and constants for the two-requester regblock CPU-interface arbiter.
// The optional stall timeout is TEST_REGBLOCK_CPUIF_ARB_TIMEOUT_EN; no types depend on it.
package test_regblock_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int OWNER_W    = 1;
    // Latched request/response fields are sized for the regblock; ADDR_W and DATA_W must not exceed these.
    localparam int ARB_ADDR_W = 4;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  is_wr;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wr_data;
    } arb_req_t;

    typedef struct packed {
        logic                  rd_ack;
        logic                  rd_err;
        logic [ARB_DATA_W-1:0] rd_data;
        logic                  wr_ack;
        logic                  wr_err;
    } arb_resp_t;

    function automatic logic [OWNER_W-1:0] other_req(input logic [OWNER_W-1:0] idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/test_regblock_rr_pick.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to prio_ptr.
// The pointer moves to the losing side on every accepted grant.
module test_regblock_rr_pick
    import test_regblock_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] grant_idx
);

    logic [OWNER_W-1:0] prio_ptr_reg;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_ptr_reg[0] ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    assign grant_idx = grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr_reg <= '0;
        end else if (advance) begin
            prio_ptr_reg <= other_req(grant_idx);
        end
    end

endmodule

// File: rtl/test_regblock_cpuif_arb.sv
// Shares the regblock CPU port between a host bridge (m0) and an init sequencer (m1),
// one transaction at a time. Optional stall timeout: TEST_REGBLOCK_CPUIF_ARB_TIMEOUT_EN.
module test_regblock_cpuif_arb
    import test_regblock_arb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
`ifdef TEST_REGBLOCK_CPUIF_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_req_is_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_req_stall,
    output logic              m0_rd_ack,
    output logic              m0_rd_err,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_wr_ack,
    output logic              m0_wr_err,

    input  logic              m1_req,
    input  logic              m1_req_is_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_req_stall,
    output logic              m1_rd_ack,
    output logic              m1_rd_err,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_wr_ack,
    output logic              m1_wr_err,

    output logic              cpuif_req,
    output logic              cpuif_req_is_wr,
    output logic [ADDR_W-1:0] cpuif_addr,
    output logic [DATA_W-1:0] cpuif_wr_data,
    input  logic              cpuif_req_stall_wr,
    input  logic              cpuif_req_stall_rd,
    input  logic              cpuif_rd_ack,
    input  logic              cpuif_rd_err,
    input  logic [DATA_W-1:0] cpuif_rd_data,
    input  logic              cpuif_wr_ack,
    input  logic              cpuif_wr_err
);

    arb_state_e         state_reg;
    arb_req_t           req_reg;
    logic [OWNER_W-1:0] owner_reg;
    logic               cpuif_req_reg;

    arb_req_t           in_req [NUM_REQ];
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] grant;
    logic [OWNER_W-1:0] grant_idx;
    logic               idle;
    logic               accept;
    logic               rel_stall;
    logic               match_ack;
    logic               issue_go;
    logic               resp_take;
    logic               timeout_fire;
    arb_resp_t          resp_next;

    assign req_vec   = {m1_req, m0_req};
    assign in_req[0] = '{is_wr: m0_req_is_wr, addr: ARB_ADDR_W'(m0_addr), wr_data: ARB_DATA_W'(m0_wr_data)};
    assign in_req[1] = '{is_wr: m1_req_is_wr, addr: ARB_ADDR_W'(m1_addr), wr_data: ARB_DATA_W'(m1_wr_data)};

    assign idle   = (state_reg == IDLE);
    assign accept = idle && (|grant);

    test_regblock_rr_pick u_rr_pick (
        .clk       (clk),
        .rst       (rst),
        .req       (req_vec),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stall is combinational so a granted requester is accepted in the same IDLE cycle.
    assign m0_req_stall = !idle || !grant[0];
    assign m1_req_stall = !idle || !grant[1];

    assign cpuif_req       = cpuif_req_reg;
    assign cpuif_req_is_wr = req_reg.is_wr;
    assign cpuif_addr      = ADDR_W'(req_reg.addr);
    assign cpuif_wr_data   = DATA_W'(req_reg.wr_data);

    assign rel_stall = req_reg.is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    assign match_ack = req_reg.is_wr ? cpuif_wr_ack : cpuif_rd_ack;
    assign issue_go  = (state_reg == ISSUE) && !rel_stall;
    // An ack while the request is still stalled, or in IDLE, belongs to nothing we issued.
    assign resp_take = (issue_go || (state_reg == WAIT_RESP)) && match_ack;

`ifdef TEST_REGBLOCK_CPUIF_ARB_TIMEOUT_EN
    localparam int TMO_W = 8;
    logic [TMO_W-1:0] tmo_cnt_reg;

    assign timeout_fire = (state_reg == ISSUE) && rel_stall
                       && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || (state_reg != ISSUE) || !rel_stall || timeout_fire) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        resp_next = '0;
        if (timeout_fire) begin
            resp_next.rd_ack = !req_reg.is_wr;
            resp_next.rd_err = !req_reg.is_wr;
            resp_next.wr_ack = req_reg.is_wr;
            resp_next.wr_err = req_reg.is_wr;
        end else if (resp_take) begin
            resp_next.rd_ack  = !req_reg.is_wr;
            resp_next.rd_err  = !req_reg.is_wr && cpuif_rd_err;
            resp_next.rd_data = req_reg.is_wr ? '0 : ARB_DATA_W'(cpuif_rd_data);
            resp_next.wr_ack  = req_reg.is_wr;
            resp_next.wr_err  = req_reg.is_wr && cpuif_wr_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_reg       <= '0;
            owner_reg     <= '0;
            cpuif_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        req_reg       <= in_req[grant_idx];
                        owner_reg     <= grant_idx;
                        cpuif_req_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (timeout_fire) begin
                        cpuif_req_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (!rel_stall) begin
                        cpuif_req_reg <= 1'b0;
                        state_reg     <= match_ack ? IDLE : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (match_ack) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    cpuif_req_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // One response register per requester; only the owner's copy ever carries an ack.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
        arb_resp_t resp_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                resp_reg <= '0;
            end else if (owner_reg == OWNER_W'(gi)) begin
                resp_reg <= resp_next;
            end else begin
                resp_reg <= '0;
            end
        end
    end

    assign m0_rd_ack  = g_resp[0].resp_reg.rd_ack;
    assign m0_rd_err  = g_resp[0].resp_reg.rd_err;
    assign m0_rd_data = DATA_W'(g_resp[0].resp_reg.rd_data);
    assign m0_wr_ack  = g_resp[0].resp_reg.wr_ack;
    assign m0_wr_err  = g_resp[0].resp_reg.wr_err;

    assign m1_rd_ack  = g_resp[1].resp_reg.rd_ack;
    assign m1_rd_err  = g_resp[1].resp_reg.rd_err;
    assign m1_rd_data = DATA_W'(g_resp[1].resp_reg.rd_data);
    assign m1_wr_ack  = g_resp[1].resp_reg.wr_ack;
    assign m1_wr_err  = g_resp[1].resp_reg.wr_err;

endmodule

// File: tb/tb_test_regblock_cpuif_arb.sv
// Directed bench for the regblock CPU-interface arbiter; the timeout steps
// run only when TEST_REGBLOCK_CPUIF_ARB_TIMEOUT_EN is defined.
module tb_test_regblock_cpuif_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_req_is_wr, m1_req, m1_req_is_wr;
    logic [3:0]  m0_addr, m1_addr;
    logic [31:0] m0_wr_data, m1_wr_data;
    logic        m0_req_stall, m0_rd_ack, m0_rd_err, m0_wr_ack, m0_wr_err;
    logic        m1_req_stall, m1_rd_ack, m1_rd_err, m1_wr_ack, m1_wr_err;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        cpuif_req, cpuif_req_is_wr;
    logic [3:0]  cpuif_addr;
    logic [31:0] cpuif_wr_data;
    logic        cpuif_req_stall_wr, cpuif_req_stall_rd;
    logic        cpuif_rd_ack, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err;
    logic [31:0] cpuif_rd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    test_regblock_cpuif_arb dut (
        .clk                (clk),
        .rst                (rst),
        .m0_req             (m0_req),
        .m0_req_is_wr       (m0_req_is_wr),
        .m0_addr            (m0_addr),
        .m0_wr_data         (m0_wr_data),
        .m0_req_stall       (m0_req_stall),
        .m0_rd_ack          (m0_rd_ack),
        .m0_rd_err          (m0_rd_err),
        .m0_rd_data         (m0_rd_data),
        .m0_wr_ack          (m0_wr_ack),
        .m0_wr_err          (m0_wr_err),
        .m1_req             (m1_req),
        .m1_req_is_wr       (m1_req_is_wr),
        .m1_addr            (m1_addr),
        .m1_wr_data         (m1_wr_data),
        .m1_req_stall       (m1_req_stall),
        .m1_rd_ack          (m1_rd_ack),
        .m1_rd_err          (m1_rd_err),
        .m1_rd_data         (m1_rd_data),
        .m1_wr_ack          (m1_wr_ack),
        .m1_wr_err          (m1_wr_err),
        .cpuif_req          (cpuif_req),
        .cpuif_req_is_wr    (cpuif_req_is_wr),
        .cpuif_addr         (cpuif_addr),
        .cpuif_wr_data      (cpuif_wr_data),
        .cpuif_req_stall_wr (cpuif_req_stall_wr),
        .cpuif_req_stall_rd (cpuif_req_stall_rd),
        .cpuif_rd_ack       (cpuif_rd_ack),
        .cpuif_rd_err       (cpuif_rd_err),
        .cpuif_rd_data      (cpuif_rd_data),
        .cpuif_wr_ack       (cpuif_wr_ack),
        .cpuif_wr_err       (cpuif_wr_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int win;
        int cnt;

        rst = 1'b1;
        m0_req = 0; m0_req_is_wr = 0; m0_addr = 0; m0_wr_data = 0;
        m1_req = 0; m1_req_is_wr = 0; m1_addr = 0; m1_wr_data = 0;
        cpuif_req_stall_wr = 0; cpuif_req_stall_rd = 0;
        cpuif_rd_ack = 0; cpuif_rd_err = 0; cpuif_rd_data = 0;
        cpuif_wr_ack = 0; cpuif_wr_err = 0;

        // Reset state
        tick(); tick();
        chk("rst_cpuif_req", cpuif_req, 0);
        chk("rst_cpuif_addr", cpuif_addr, 0);
        chk("rst_m0_wr_ack", m0_wr_ack, 0);
        chk("rst_m1_rd_data", m1_rd_data, 0);
        rst = 1'b0;
        tick();

        // m0 writes 0xA5 to 0x4, same-cycle wr_ack
        m0_req = 1; m0_req_is_wr = 1; m0_addr = 4'h4; m0_wr_data = 32'h0000_00A5;
        #1;
        chk("wr_m0_stall_T", m0_req_stall, 0);
        chk("wr_m1_stall_T", m1_req_stall, 1);
        tick();
        m0_req = 0; #1;
        chk("wr_cpuif_req_T1", cpuif_req, 1);
        chk("wr_cpuif_addr_T1", cpuif_addr, 4'h4);
        chk("wr_cpuif_is_wr_T1", cpuif_req_is_wr, 1);
        chk("wr_cpuif_data_T1", cpuif_wr_data, 32'hA5);
        chk("wr_m0_stall_T1", m0_req_stall, 1);
        cpuif_wr_ack = 1;
        tick();
        cpuif_wr_ack = 0; #1;
        chk("wr_m0_wr_ack_T2", m0_wr_ack, 1);
        chk("wr_m0_wr_err_T2", m0_wr_err, 0);
        chk("wr_m1_wr_ack_T2", m1_wr_ack, 0);
        chk("wr_m1_rd_ack_T2", m1_rd_ack, 0);
        chk("wr_cpuif_req_T2", cpuif_req, 0);
        tick();
        chk("wr_m0_wr_ack_T3", m0_wr_ack, 0);

        // Fresh reset, then both request reads continuously: grant alternates m0, m1, ...
        rst = 1; tick(); rst = 0;
        m0_req = 1; m0_req_is_wr = 0; m0_addr = 4'h0;
        m1_req = 1; m1_req_is_wr = 0; m1_addr = 4'h8;
        for (int i = 0; i < 8; i++) begin
            #1;
            win = i % 2;
            chk($sformatf("rr%0d_m0_stall", i), m0_req_stall, (win == 1));
            chk($sformatf("rr%0d_m1_stall", i), m1_req_stall, (win == 0));
            chk($sformatf("rr%0d_m0_rd_ack", i), m0_rd_ack, (i > 0 && win == 1));
            chk($sformatf("rr%0d_m1_rd_ack", i), m1_rd_ack, (i > 0 && win == 0));
            chk($sformatf("rr%0d_m0_rd_data", i), m0_rd_data, (i > 0 && win == 1) ? 32'hC0 + i - 1 : 0);
            tick();
            chk($sformatf("rr%0d_cpuif_req", i), cpuif_req, 1);
            chk($sformatf("rr%0d_cpuif_addr", i), cpuif_addr, (win == 1) ? 4'h8 : 4'h0);
            cpuif_rd_ack = 1; cpuif_rd_data = 32'hC0 + i;
            tick();
            cpuif_rd_ack = 0; cpuif_rd_data = 0;
        end
        m0_req = 0; m1_req = 0; #1;
        chk("rr_last_m1_rd_ack", m1_rd_ack, 1);
        chk("rr_last_m1_rd_data", m1_rd_data, 32'hC7);
        chk("rr_last_m0_rd_ack", m0_rd_ack, 0);

        // m1 read 0x8 with three stall cycles
        tick();
        m1_req = 1; m1_req_is_wr = 0; m1_addr = 4'h8; #1;
        chk("st_m1_stall", m1_req_stall, 0);
        tick();
        m1_req = 0; cpuif_req_stall_rd = 1; #1;
        chk("st_cpuif_req_c1", cpuif_req, 1);
        tick();
        chk("st_cpuif_req_c2", cpuif_req, 1);
        chk("st_cpuif_addr_c2", cpuif_addr, 4'h8);
        tick();
        chk("st_cpuif_req_c3", cpuif_req, 1);
        tick();
        cpuif_req_stall_rd = 0; cpuif_rd_ack = 1; cpuif_rd_data = 32'h1234_5678; #1;
        chk("st_cpuif_req_c4", cpuif_req, 1);
        tick();
        cpuif_rd_ack = 0; cpuif_rd_data = 0; #1;
        chk("st_m1_rd_ack", m1_rd_ack, 1);
        chk("st_m1_rd_data", m1_rd_data, 32'h1234_5678);
        chk("st_m1_rd_err", m1_rd_err, 0);
        chk("st_m0_rd_ack", m0_rd_ack, 0);
        chk("st_cpuif_req_done", cpuif_req, 0);
        tick();
        chk("st_m1_rd_data_after", m1_rd_data, 0);

        // Downstream write error on an m0 write
        m0_req = 1; m0_req_is_wr = 1; m0_addr = 4'h8; m0_wr_data = 32'h1; #1;
        tick();
        m0_req = 0; cpuif_wr_ack = 1; cpuif_wr_err = 1;
        tick();
        cpuif_wr_ack = 0; cpuif_wr_err = 0; #1;
        chk("we_m0_wr_ack", m0_wr_ack, 1);
        chk("we_m0_wr_err", m0_wr_err, 1);
        chk("we_m1_wr_ack", m1_wr_ack, 0);

        // Stray ack in IDLE, then wrong-direction ack while a write is outstanding
        tick();
        cpuif_rd_ack = 1; cpuif_rd_data = 32'hDEAD;
        tick();
        cpuif_rd_ack = 0; cpuif_rd_data = 0; #1;
        chk("stray_m0_rd_ack", m0_rd_ack, 0);
        chk("stray_m1_rd_ack", m1_rd_ack, 0);
        m0_req = 1; m0_req_is_wr = 1; m0_addr = 4'h0; m0_wr_data = 32'h5A; #1;
        tick();
        m0_req = 0; cpuif_rd_ack = 1;
        tick();
        cpuif_rd_ack = 0; #1;
        chk("wd_m0_rd_ack", m0_rd_ack, 0);
        chk("wd_m0_wr_ack", m0_wr_ack, 0);
        chk("wd_cpuif_req", cpuif_req, 0);
        cpuif_wr_ack = 1;
        tick();
        cpuif_wr_ack = 0; #1;
        chk("wd_m0_wr_ack_late", m0_wr_ack, 1);

        // Reset while waiting for a read response, then a late ack
        tick();
        m0_req = 1; m0_req_is_wr = 0; m0_addr = 4'h4; #1;
        tick();
        m0_req = 0;
        tick();
        chk("rw_cpuif_req_wait", cpuif_req, 0);
        chk("rw_m0_stall_wait", m0_req_stall, 1);
        rst = 1;
        tick();
        rst = 0; cpuif_rd_ack = 1; cpuif_rd_data = 32'hBAD;
        tick();
        cpuif_rd_ack = 0; cpuif_rd_data = 0; #1;
        chk("rw_m0_rd_ack", m0_rd_ack, 0);
        chk("rw_m1_rd_ack", m1_rd_ack, 0);
        chk("rw_m0_rd_data", m0_rd_data, 0);
        m0_req = 1; m0_addr = 4'h4; m1_req = 1; m1_req_is_wr = 0; m1_addr = 4'h0; #1;
        chk("rw_grant_m0_stall", m0_req_stall, 0);
        chk("rw_grant_m1_stall", m1_req_stall, 1);
        tick();
        m0_req = 0; m1_req = 0; cpuif_rd_ack = 1; cpuif_rd_data = 32'h77; #1;
        chk("rw_cpuif_addr", cpuif_addr, 4'h4);
        tick();
        cpuif_rd_ack = 0; cpuif_rd_data = 0; #1;
        chk("rw_m0_rd_ack_after", m0_rd_ack, 1);
        chk("rw_m0_rd_data_after", m0_rd_data, 32'h77);

`ifdef TEST_REGBLOCK_CPUIF_ARB_TIMEOUT_EN
        // Stall held for 40 cycles: request abandoned after 16, owner sees an error ack
        tick();
        m0_req = 1; m0_req_is_wr = 0; m0_addr = 4'h8; #1;
        tick();
        m0_req = 0; cpuif_req_stall_rd = 1; cpuif_rd_data = 32'hFFFF_FFFF; #1;
        cnt = 0;
        while (cpuif_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, 16);
        chk("to_m0_rd_ack", m0_rd_ack, 1);
        chk("to_m0_rd_err", m0_rd_err, 1);
        chk("to_m0_rd_data", m0_rd_data, 0);
        chk("to_m1_rd_ack", m1_rd_ack, 0);
        repeat (40 - cnt - 1) tick();
        chk("to_no_reissue", cpuif_req, 0);
        cpuif_req_stall_rd = 0; cpuif_rd_data = 0;
        m1_req = 1; m1_req_is_wr = 0; m1_addr = 4'h0; #1;
        chk("to_idle_m1_stall", m1_req_stall, 0);
        tick();
        m1_req = 0; cpuif_rd_ack = 1;
        tick();
        cpuif_rd_ack = 0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
